// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: opcodes, instruction
// field positions and the default PC reset value.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/en_reg.sv
// Generic enabled register with asynchronous active-low reset to a
// configurable value.
module en_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Nonarchitectural state around the multicycle control unit: PC, IR, MDR and
// ALUOut, plus the memory address mux and decode field taps.
module pc_ir_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWrite,
  input  logic                 Branch,
  input  logic                 PCSrc,
  input  logic                 IRWrite,
  input  logic                 lord,
  input  logic                 Zero,
  input  logic [WIDTH-1:0]     ALUResult,
  input  logic [WIDTH-1:0]     ReadData,
  output logic [WIDTH-1:0]     Adr,
  output logic [WIDTH-1:0]     PC,
  output logic [WIDTH-1:0]     Instr,
  output logic [5:0]           Opcode,
  output logic [5:0]           Funct,
  output logic [4:0]           Rs,
  output logic [4:0]           Rt,
  output logic [4:0]           Rd,
  output logic [15:0]          Imm,
  output logic [WIDTH-1:0]     Data,
  output logic [WIDTH-1:0]     ALUOut,
  output logic                 PCEn,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic                 misalign_err
);

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [WIDTH-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

  logic [WIDTH-1:0] pc_next_p0;
  logic [WIDTH-1:0] pc_load_p0;

  assign PCEn       = PCWrite | (Branch & Zero);
  assign pc_next_p0 = PCSrc ? ALUOut : ALUResult;
  assign pc_load_p0 = word_align(pc_next_p0);

  // p0 -> p1: all four state registers capture on the same edge
  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (PCEn),
    .d   (pc_load_p0),
    .q   (PC)
  );

  en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
    .clk (clk),
    .rst (rst),
    .en  (IRWrite),
    .d   (ReadData),
    .q   (Instr)
  );

  en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (ReadData),
    .q   (Data)
  );

  en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_aluout (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (ALUResult),
    .q   (ALUOut)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (IRWrite) begin
        fetch_count <= fetch_count + CNT_WIDTH'(1);
      end
      // Sticky: only reset clears it
      if (PCEn && is_misaligned(pc_next_p0)) begin
        misalign_err <= 1'b1;
      end
    end
  end

  assign Adr = lord ? ALUOut : PC;

  assign Opcode = Instr[OPCODE_MSB:OPCODE_LSB];
  assign Funct  = Instr[FUNCT_MSB:FUNCT_LSB];
  assign Rs     = Instr[RS_MSB:RS_LSB];
  assign Rt     = Instr[RT_MSB:RT_LSB];
  assign Rd     = Instr[RD_MSB:RD_LSB];
  assign Imm    = Instr[IMM_MSB:IMM_LSB];

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
Front-end register stage of the multicycle MIPS datapath. It holds the nonarchitectural state around the control unit: the PC, the Instruction Register, the Memory Data Register and the ALUOut register. It consumes the control unit's PCWrite/Branch/PCSrc/IRWrite/lord strobes. It feeds Opcode/Funct back to the control unit and supplies the memory address.

Parameters:
WIDTH, 32, datapath word width
RESET_PC, 32'h0000_0000, PC value after reset (word aligned)
CNT_WIDTH, 16, width of the fetched-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
PCWrite  in  1  unconditional PC update strobe from control unit
Branch  in  1  conditional PC update strobe (beq)
PCSrc  in  1  next-PC select: 0 = ALUResult, 1 = ALUOut
IRWrite  in  1  load Instruction Register from ReadData
lord  in  1  address select: 0 = PC, 1 = ALUOut
Zero  in  1  ALU zero flag
ALUResult  in  WIDTH  combinational ALU result
ReadData  in  WIDTH  memory read data
Adr  out  WIDTH  memory address
PC  out  WIDTH  current PC
Instr  out  WIDTH  Instruction Register contents
Opcode  out  6  Instr[31:26], to control unit
Funct  out  6  Instr[5:0], to control unit
Rs  out  5  Instr[25:21]
Rt  out  5  Instr[20:16]
Rd  out  5  Instr[15:11]
Imm  out  16  Instr[15:0]
Data  out  WIDTH  Memory Data Register
ALUOut  out  WIDTH  registered ALU result
PCEn  out  1  PC load enable (observability)
fetch_count  out  CNT_WIDTH  number of IR loads since reset
misalign_err  out  1  sticky flag: non-word-aligned PC target seen

Behaviour:
- Reset (rst=0, async, immediate): PC=RESET_PC; Instr=0; Data=0; ALUOut=0; fetch_count=0; misalign_err=0.
- PCEn = PCWrite | (Branch & Zero), combinational.
- PCNext = PCSrc ? ALUOut : ALUResult.
- On a rising edge with PCEn=1: PC <= {PCNext[WIDTH-1:2], 2'b00}. If PCNext[1:0] != 0, misalign_err <= 1. The flag is sticky until reset.
- PCEn=0 (including Branch=1 with Zero=0): PC holds.
- PCWrite and Branch both high: a single load. Result is identical to PCWrite alone.
- IRWrite=1 on a rising edge: Instr <= ReadData, and fetch_count <= fetch_count+1, wrapping from all-ones to 0.
- IRWrite=0: Instr and fetch_count hold.
- Data <= ReadData every cycle; no enable.
- ALUOut <= ALUResult every cycle; no enable.
- Adr = lord ? ALUOut : PC, combinational. There is no register on Adr.
- Field outputs are combinational slices of Instr. Opcode/Funct change only the cycle after an IRWrite edge, which gives the control FSM a stable decode.
- Simultaneous PCEn and IRWrite (fetch state): both registers update on the same edge. Instr captures ReadData addressed by the old PC.
- Reset asserted mid-instruction: all state returns to reset values asynchronously. After deassertion, the first edge with IRWrite fetches from RESET_PC.
- Latency: every register loads one cycle after its enable is sampled; Adr has zero latency.

Decomposition:
- Package mips_pkg:
  - opcode constants (OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_ADDI=6'h08, OP_J=6'h02)
  - instruction field bit positions
  - default RESET_PC
- Sub-module en_reg: parameterized WIDTH register with enable, async active-low reset and a reset-value parameter.
- en_reg is instantiated for PC, IR, MDR (enable tied 1) and ALUOut (enable tied 1).

Test Plan:
- Reset: hold rst=0 with random inputs, then release -> PC=0, Instr=0, fetch_count=0, misalign_err=0, Adr=0 with lord=0.
- Fetch: ReadData=32'h8C08_0004 (lw), ALUResult=4, PCWrite=1, IRWrite=1, PCSrc=0, one edge -> PC=4, Opcode=6'h23, Rt=8, Imm=4, fetch_count=1.
- Branch taken/not: ALUResult=32'h40 then ALUOut=32'h40; Branch=1, PCSrc=1.
  - Zero=1 -> PC=32'h40.
  - Repeat with Zero=0 -> PC unchanged, PCEn=0.
- Address mux: ALUResult=32'h100 for one edge, then lord=1 -> Adr=32'h100; lord=0 -> Adr=PC.
- Misalign: PCWrite=1, ALUResult=32'h0000_0006 -> PC=32'h4, misalign_err=1; flag stays set after further aligned jumps until rst=0.
- Counter wrap and async reset: preload fetch_count to all-ones via 65535 IRWrite pulses, then one more -> fetch_count=0. Assert rst mid-cycle -> outputs clear before the next edge.
